// File: rtl/sensors_averager.sv
// Snapshot sensor readings, sum active ones serially and divide by
// the active count with a 16-step restoring divider.
module sensors_averager #(
  parameter int unsigned NR_SENSORS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [NR_SENSORS*8-1:0] sensors_data_i,
  input  logic [NR_SENSORS-1:0]   sensors_en_i,
  output logic [15:0]             temp_Q_o,
  output logic [15:0]             temp_R_o,
  output logic [7:0]              active_sensors_nr_o,
  output logic                    div_by_zero_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIVIDE,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(NR_SENSORS - 1);

  state_t                  state_q, state_d;
  logic [NR_SENSORS*8-1:0] data_q, data_d;
  logic [NR_SENSORS-1:0]   en_q, en_d;
  logic [15:0]             sum_q, sum_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              idx_q, idx_d;
  logic [15:0]             dvd_q, dvd_d;
  logic [7:0]              dvs_q, dvs_d;
  logic [8:0]              part_q, part_d;
  logic [15:0]             quo_q, quo_d;
  logic [3:0]              step_q, step_d;
  logic [15:0]             q_q, q_d;
  logic [15:0]             r_q, r_d;
  logic [7:0]              nr_q, nr_d;
  logic                    dbz_q, dbz_d;

  logic [7:0]  cur_data;
  logic        cur_en;
  logic [15:0] sum_acc;
  logic [7:0]  cnt_acc;
  logic [8:0]  shifted;
  logic        fits;

  assign cur_data = data_q[{idx_q, 3'b000} +: 8];
  assign cur_en   = en_q[idx_q];
  assign sum_acc  = sum_q + (cur_en ? {8'b0, cur_data} : 16'd0);
  assign cnt_acc  = cnt_q + {7'b0, cur_en};
  // Partial remainder stays below the divisor, so its low 8 bits suffice.
  assign shifted  = {part_q[7:0], dvd_q[step_q]};
  assign fits     = shifted >= {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    en_d    = en_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    quo_d   = quo_q;
    step_d  = step_q;
    q_d     = q_q;
    r_d     = r_q;
    nr_d    = nr_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          data_d  = sensors_data_i;
          en_d    = sensors_en_i;
          sum_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        sum_d = sum_acc;
        cnt_d = cnt_acc;
        idx_d = idx_q + 8'd1;
        if (idx_q == LAST) begin
          if (cnt_acc == 8'd0) begin
            q_d     = '0;
            r_d     = '0;
            nr_d    = '0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = sum_acc;
            dvs_d   = cnt_acc;
            part_d  = '0;
            quo_d   = '0;
            step_d  = 4'd15;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        part_d         = fits ? shifted - {1'b0, dvs_q} : shifted;
        quo_d[step_q]  = fits;
        step_d         = step_q - 4'd1;
        if (step_q == 4'd0) begin
          q_d     = quo_d;
          r_d     = {7'b0, part_d};
          nr_d    = cnt_q;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      en_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      quo_q   <= '0;
      step_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      nr_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_q    <= en_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      quo_q   <= quo_d;
      step_q  <= step_d;
      q_q     <= q_d;
      r_q     <= r_d;
      nr_q    <= nr_d;
      dbz_q   <= dbz_d;
    end
  end

  assign temp_Q_o            = q_q;
  assign temp_R_o            = r_q;
  assign active_sensors_nr_o = nr_q;
  assign div_by_zero_o       = dbz_q;
  assign busy_o              = state_q != IDLE;
  assign done_o              = state_q == DONE;

endmodule

// File: tb/tb_sensors_averager.sv
// Directed and random checks of sensors_averager against an
// arithmetic reference model.
module tb_sensors_averager;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N*8-1:0] data = '0;
  logic [N-1:0]  en = '0;
  logic [15:0]   q, r;
  logic [7:0]    nr;
  logic          dbz, busy, done;

  int npass = 0;
  int ntot = 0;

  sensors_averager #(.NR_SENSORS(N)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .start_i             (start),
    .sensors_data_i      (data),
    .sensors_en_i        (en),
    .temp_Q_o            (q),
    .temp_R_o            (r),
    .active_sensors_nr_o (nr),
    .div_by_zero_o       (dbz),
    .busy_o              (busy),
    .done_o              (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // mode 0: plain run; mode 1: disturb inputs and start while busy
  task automatic run(input logic [N*8-1:0] d, input logic [N-1:0] m,
                     input int mode, input string tag);
    int sum, cnt, n, dones, eq, er, lat;
    logic [7:0] b;
    sum = 0;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      b = d[i*8 +: 8];
      if (m[i]) begin
        sum += int'(b);
        cnt++;
      end
    end
    eq  = (cnt == 0) ? 0 : sum / cnt;
    er  = (cnt == 0) ? 0 : sum % cnt;
    lat = (cnt == 0) ? N : N + 16;
    data  = d;
    en    = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busy"}, int'(busy), 1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (mode == 1) begin
        if (n == 3 || n == 12) begin
          start = 1'b1;
          data  = {$urandom, $urandom};
          en    = N'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".Q"}, int'(q), eq);
    chk({tag, ".R"}, int'(r), er);
    chk({tag, ".nr"}, int'(nr), cnt);
    chk({tag, ".dbz"}, int'(dbz), int'(cnt == 0));
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk({tag, ".extra_done"}, dones, 0);
    chk({tag, ".idle"}, int'(busy), 0);
    chk({tag, ".hold_Q"}, int'(q), eq);
  endtask

  function automatic logic [N*8-1:0] pack(input int v0, input int v1,
    input int v2, input int v3, input int v4, input int v5,
    input int v6, input int v7);
    return {8'(v7), 8'(v6), 8'(v5), 8'(v4), 8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  initial begin
    int dn;
    logic [N*8-1:0] sd;
    logic [N-1:0] sm;
    #2;
    chk("rst.Q", int'(q), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.dbz", int'(dbz), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(pack(20, 21, 22, 23, 24, 25, 26, 27), 8'hff, 0, "seq");
    run(pack(20, 20, 21, 99, 99, 99, 99, 99), 8'h07, 0, "mask3");
    run(pack(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, 0, "zero");
    run(pack(0, 0, 0, 0, 0, 0, 0, 30), 8'h80, 0, "one");
    run(pack(255, 255, 255, 255, 255, 255, 255, 255), 8'hff, 0, "max");
    run(pack(255, 255, 255, 255, 255, 255, 255, 0), 8'hff, 0, "max7");
    run(pack(10, 77, 3, 200, 5, 9, 140, 61), 8'h5b, 1, "disturb");

    // reset mid-divide
    data  = pack(10, 20, 30, 40, 50, 60, 70, 80);
    en    = 8'hff;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (N + 5) @(posedge clk);
    #1;
    chk("pre_rst.busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.Q", int'(q), 0);
    chk("arst.R", int'(r), 0);
    chk("arst.nr", int'(nr), 0);
    chk("arst.busy", int'(busy), 0);
    dn = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("arst.no_done", dn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(pack(10, 20, 30, 40, 50, 60, 70, 80), 8'hff, 0, "after_rst");

    for (int k = 0; k < 10; k++) begin
      sd = {$urandom, $urandom};
      sm = (k % 4 == 3) ? 8'h00 : N'($urandom);
      run(sd, sm, k % 2, "rand");
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
